regfile_np: RTL and testbench
=============================

REGFILE_NP -- requirements
Module: regfile_np

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, the width of each register entry in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, so DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter NUM_RD, default 2, range 1..4, the number of independent read ports.
REQ-004 SHALL have parameter WRITE_FIRST, default 1; 1 selects write-first read mode, 0 selects read-first.
REQ-005 SHALL have parameter ZERO_REG, default 0; 1 hardwires entry 0 to zero.
REQ-006 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port rd_addr, input, NUM_RD*ADDR_WIDTH bits: read addresses, port i in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port rd_data, output, NUM_RD*DATA_WIDTH bits: read data, port i in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port wr_addr, input, ADDR_WIDTH bits: write address.
REQ-011 SHALL have port wr_data, input, DATA_WIDTH bits: write data.
REQ-012 SHALL have port wen, input, 1 bit: write enable.
REQ-013 SHALL have port stall, input, 1 bit: freezes the read ports.
REQ-014 SHALL have port busy, output, 1 bit: high while the clear sequencer runs.

Function
REQ-015 SHALL use a two-state FSM, CLEAR and RUN; rst low forces CLEAR with the clear counter at 0.
REQ-016 In CLEAR, with rst high, SHALL write 0 to entry clr_cnt on each rising edge and then increment clr_cnt; the edge that writes entry DEPTH-1 SHALL move the FSM to RUN.
REQ-017 busy SHALL be 1 in CLEAR and 0 in RUN; it SHALL be high for exactly DEPTH rising edges after rst goes high.
REQ-018 wen SHALL be ignored in CLEAR.
REQ-019 All rd_data slices SHALL read 0 in CLEAR.
REQ-020 In RUN, wen=1 SHALL write wr_data to entry wr_addr on the rising edge; stall SHALL NOT block writes.
REQ-021 With ZERO_REG=1, writes to address 0 SHALL be dropped and reads of address 0 SHALL return 0 in both modes.
REQ-022 Read latency SHALL be 1 cycle: the address presented at edge N is reflected on rd_data after edge N.
REQ-023 With WRITE_FIRST=1, each port SHALL register its address when stall=0, and rd_data[i] SHALL equal the current contents of the entry at the registered address (mem[raddr_q[i]]).
REQ-024 With WRITE_FIRST=1, a same-edge write to the read address SHALL return the new data after that edge.
REQ-025 With WRITE_FIRST=1 and stall=1, the registered address SHALL be held, and a write to it SHALL appear on rd_data after the write edge.
REQ-026 With WRITE_FIRST=0, each port SHALL register mem[rd_addr] when stall=0; a same-edge write SHALL return the old data.
REQ-027 With WRITE_FIRST=0 and stall=1, the registered data SHALL be held unchanged regardless of writes.
REQ-028 All read ports SHALL be fully independent; any number of ports may read the same address without conflict.
REQ-029 Storage SHALL be a single array with one write port and synchronous reads, so that it is inferable as block RAM when ZERO_REG=0.

Reset
REQ-030 While rst=0 at a rising edge: FSM enters CLEAR, clr_cnt=0, busy=1, rd_data=0, registered read addresses and data=0, no array write.
REQ-031 rst asserted mid-clear or mid-operation SHALL restart the clear from entry 0 when rst releases.

Verification (DATA_WIDTH=4, ADDR_WIDTH=5, NUM_RD=2 unless stated)
REQ-032 Release rst -> busy=1 for exactly 32 edges, then 0. During clear, wen=1 at addr 3 with data 0xA -> after busy falls, port 0 reading addr 3 returns 0x0.
REQ-033 WRITE_FIRST=1: write 0x5 to addr 7 on the same edge port 0 samples addr 7 -> port 0 reads 0x5 after the edge. WRITE_FIRST=0, same stimulus -> 0x0 after the edge, 0x5 one cycle later.
REQ-034 stall=1 with port 1 holding addr 9, write 0xC to addr 9. WRITE_FIRST=1 -> port 1 shows 0xC after the write edge. WRITE_FIRST=0 -> the old value is held until stall=0, then 0xC.
REQ-035 ZERO_REG=1: write 0xF to addr 0 -> both ports read 0x0 at addr 0; write 0xF to addr 1 -> both ports read 0xF at addr 1.
REQ-036 Pulse rst low for 1 cycle when busy has been 0 for 10 cycles -> busy=1 for 32 edges, and all 32 entries read 0x0 afterwards on both ports.
REQ-037 NUM_RD=4: all ports read addr 31 after writing 0x6 -> every port returns 0x6 with 1-cycle latency.

Source files
------------

// File: rtl/regfile_np.sv
// regfile_np: parameterised multi-read register file with clear sequencer and write-first/read-first modes
module regfile_np #(
   parameter int DATA_WIDTH  = 4,
   parameter int ADDR_WIDTH  = 5,
   parameter int NUM_RD      = 2,
   parameter int WRITE_FIRST = 1,
   parameter int ZERO_REG    = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
   input  logic [ADDR_WIDTH-1:0]        wr_addr,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic                         wen,
   input  logic                         stall,
   output logic                         busy
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   typedef enum logic {CLEAR, RUN} state_t;
   state_t                  state;
   logic [ADDR_WIDTH-1:0]   clr_cnt;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic                    we;
   logic [ADDR_WIDTH-1:0]   wa;
   logic [DATA_WIDTH-1:0]   wd;
   always_comb begin
      we = rst && (state == CLEAR || (wen && !(ZERO_REG != 0 && wr_addr == '0)));
      wa = state == CLEAR ? clr_cnt : wr_addr;
      wd = state == CLEAR ? '0 : wr_data;
   end
   always_ff @(posedge clk)
      if (we) mem[wa] <= wd;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         busy    <= 1'b1;
      end else if (state == CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
         if (&clr_cnt) begin
            state <= RUN;
            busy  <= 1'b0;
         end
      end
   end
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      assign ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (WRITE_FIRST != 0) begin : g_wf
         logic [ADDR_WIDTH-1:0] raddr_q;
         always_ff @(posedge clk)
            if (!rst) raddr_q <= '0;
            else if (!stall) raddr_q <= ra;
         assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
            (state == CLEAR || (ZERO_REG != 0 && raddr_q == '0)) ? '0 : mem[raddr_q];
      end else begin : g_rf
         logic [DATA_WIDTH-1:0] rdata_q;
         always_ff @(posedge clk)
            if (!rst) rdata_q <= '0;
            else if (!stall) rdata_q <= (ZERO_REG != 0 && ra == '0) ? '0 : mem[ra];
         assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = state == CLEAR ? '0 : rdata_q;
      end
   end
endmodule

// File: tb/tb_regfile_np.sv
// tb_regfile_np: directed checks of regfile_np across write-first, read-first, zero-reg and 4-port builds
module tb_regfile_np;
   logic        clk = 1'b0;
   logic        rst, wen, stall;
   logic [4:0]  wr_addr, ra0, ra1;
   logic [3:0]  wr_data;
   logic [9:0]  ra;
   logic [19:0] ra4;
   logic [7:0]  rd_wf, rd_rf, rd_zr;
   logic [15:0] rd_4;
   logic        b_wf, b_rf, b_zr, b_4;
   int          total = 0;
   int          bad = 0;
   int          n;
   assign ra = {ra1, ra0};
   always #5 clk = ~clk;
   regfile_np #(.WRITE_FIRST(1)) u_wf (.clk(clk), .rst(rst), .rd_addr(ra), .rd_data(rd_wf),
      .wr_addr(wr_addr), .wr_data(wr_data), .wen(wen), .stall(stall), .busy(b_wf));
   regfile_np #(.WRITE_FIRST(0)) u_rf (.clk(clk), .rst(rst), .rd_addr(ra), .rd_data(rd_rf),
      .wr_addr(wr_addr), .wr_data(wr_data), .wen(wen), .stall(stall), .busy(b_rf));
   regfile_np #(.ZERO_REG(1)) u_zr (.clk(clk), .rst(rst), .rd_addr(ra), .rd_data(rd_zr),
      .wr_addr(wr_addr), .wr_data(wr_data), .wen(wen), .stall(stall), .busy(b_zr));
   regfile_np #(.NUM_RD(4)) u_4 (.clk(clk), .rst(rst), .rd_addr(ra4), .rd_data(rd_4),
      .wr_addr(wr_addr), .wr_data(wr_data), .wen(wen), .stall(stall), .busy(b_4));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic count_clear(input string tag);
      n = 0;
      do begin
         step();
         n++;
         if (n == 10) begin
            chk({tag, "_rd_in_clear_wf"}, 32'(rd_wf), 32'h0);
            chk({tag, "_rd_in_clear_rf"}, 32'(rd_rf), 32'h0);
         end
      end while (b_wf && n < 100);
      chk({tag, "_busy_edges"}, n, 32);
      chk({tag, "_busy_rf_low"}, 32'(b_rf), 32'h0);
   endtask
   initial begin
      rst = 1'b0; wen = 1'b0; stall = 1'b0;
      wr_addr = '0; wr_data = '0; ra0 = '0; ra1 = '0; ra4 = '0;
      step(); step();
      chk("rst_busy_wf", 32'(b_wf), 32'h1);
      chk("rst_busy_4", 32'(b_4), 32'h1);
      chk("rst_rd_wf", 32'(rd_wf), 32'h0);
      chk("rst_rd_rf", 32'(rd_rf), 32'h0);
      // first clear, with a write attempt that must be ignored
      rst = 1'b1; wen = 1'b1; wr_addr = 5'd3; wr_data = 4'hA; ra0 = 5'd3;
      count_clear("clr1");
      wen = 1'b0;
      step();
      chk("clr_wen_ign_wf", 32'(rd_wf[3:0]), 32'h0);
      chk("clr_wen_ign_rf", 32'(rd_rf[3:0]), 32'h0);
      // same-edge write and read
      ra0 = 5'd7; wen = 1'b1; wr_addr = 5'd7; wr_data = 4'h5;
      step();
      wen = 1'b0;
      chk("wf_same_edge", 32'(rd_wf[3:0]), 32'h5);
      chk("rf_same_edge_old", 32'(rd_rf[3:0]), 32'h0);
      step();
      chk("rf_next_new", 32'(rd_rf[3:0]), 32'h5);
      chk("wf_hold_new", 32'(rd_wf[3:0]), 32'h5);
      // stall behaviour
      ra1 = 5'd9;
      step();
      chk("p1_addr9_wf", 32'(rd_wf[7:4]), 32'h0);
      chk("p1_addr9_rf", 32'(rd_rf[7:4]), 32'h0);
      stall = 1'b1; ra1 = 5'd2; wen = 1'b1; wr_addr = 5'd9; wr_data = 4'hC;
      step();
      wen = 1'b0;
      chk("stall_wr_wf", 32'(rd_wf[7:4]), 32'hC);
      chk("stall_wr_rf", 32'(rd_rf[7:4]), 32'h0);
      chk("stall_p0_wf", 32'(rd_wf[3:0]), 32'h5);
      step();
      chk("stall_hold_rf", 32'(rd_rf[7:4]), 32'h0);
      chk("stall_hold_wf", 32'(rd_wf[7:4]), 32'hC);
      stall = 1'b0; ra1 = 5'd9;
      step();
      chk("unstall_rf", 32'(rd_rf[7:4]), 32'hC);
      chk("unstall_wf", 32'(rd_wf[7:4]), 32'hC);
      // zero register
      ra0 = 5'd0; ra1 = 5'd0; wen = 1'b1; wr_addr = 5'd0; wr_data = 4'hF;
      step();
      wen = 1'b0;
      step();
      chk("zr_a0_p0", 32'(rd_zr[3:0]), 32'h0);
      chk("zr_a0_p1", 32'(rd_zr[7:4]), 32'h0);
      chk("nozr_a0_p0", 32'(rd_wf[3:0]), 32'hF);
      ra0 = 5'd1; ra1 = 5'd1; wen = 1'b1; wr_addr = 5'd1; wr_data = 4'hF;
      step();
      wen = 1'b0;
      chk("zr_a1_p0", 32'(rd_zr[3:0]), 32'hF);
      chk("zr_a1_p1", 32'(rd_zr[7:4]), 32'hF);
      // four read ports on one address
      ra4 = '0; wen = 1'b1; wr_addr = 5'd31; wr_data = 4'h6;
      step();
      wen = 1'b0;
      chk("p4_a0_before", 32'(rd_4[3:0]), 32'hF);
      ra4 = {4{5'd31}};
      #2;
      chk("p4_latency", 32'(rd_4[3:0]), 32'hF);
      step();
      for (int p = 0; p < 4; p++) chk($sformatf("p4_port%0d", p), 32'(rd_4[p*4 +: 4]), 32'h6);
      // reset pulse after idle operation
      repeat (10) step();
      chk("idle_busy", 32'(b_wf), 32'h0);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("rst2_busy", 32'(b_wf), 32'h1);
      chk("rst2_rd_zero", 32'(rd_wf), 32'h0);
      count_clear("clr2");
      for (int a = 0; a < 32; a++) begin
         ra0 = 5'(a); ra1 = 5'(31 - a);
         step();
         chk($sformatf("clr2_wf_a%0d", a), 32'(rd_wf), 32'h0);
         chk($sformatf("clr2_rf_a%0d", a), 32'(rd_rf), 32'h0);
      end
      // reset during clear restarts from entry 0
      rst = 1'b0;
      step();
      rst = 1'b1;
      repeat (5) step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      count_clear("clr3");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
